cif_mchbuf: RTL and testbench

Single-clock, multi-channel command/event buffer in the CIF path, sitting between the chain-control side and the LLDMA engine after clock crossing. It accepts CH_NUM independent command streams, buffers each in its own FIFO, and round-robin arbitrates them onto one tagged command output. Returning events carry a channel ID and are demultiplexed into per-channel event FIFOs. Events with an illegal channel ID are dropped and counted.

---
 rtl/cif_mchbuf_if.sv | 37 +++
 rtl/cif_mchbuf.sv | 180 ++++++++++++++++++
 tb/tb_cif_mchbuf.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cif_mchbuf_if.sv
// rtl/cif_mchbuf_if.sv - command/event bus bundle between chain control, buffer and LLDMA engine
interface cif_mchbuf_if #(
  parameter int CH_NUM = 4,
  parameter int CMD_W  = 64,
  parameter int EVE_W  = 128,
  parameter int CHID_W = 4
);
  logic [CH_NUM-1:0]       transfer_cmd_valid;
  logic [CH_NUM*CMD_W-1:0] transfer_cmd_data;
  logic [CH_NUM-1:0]       transfer_cmd_ready;
  logic [CH_NUM-1:0]       transfer_eve_valid;
  logic [CH_NUM*EVE_W-1:0] transfer_eve_data;
  logic [CH_NUM-1:0]       transfer_eve_ready;
  logic                    cmd_valid;
  logic [CMD_W-1:0]        cmd_data;
  logic [CHID_W-1:0]       cmd_chid;
  logic                    cmd_ready;
  logic                    eve_valid;
  logic [EVE_W-1:0]        eve_data;
  logic [CHID_W-1:0]       eve_chid;
  logic                    eve_ready;
  logic [15:0]             eve_drop_cnt;

  modport slave (
    input  transfer_cmd_valid, transfer_cmd_data, transfer_eve_ready,
    input  cmd_ready, eve_valid, eve_data, eve_chid,
    output transfer_cmd_ready, transfer_eve_valid, transfer_eve_data,
    output cmd_valid, cmd_data, cmd_chid, eve_ready, eve_drop_cnt
  );

  modport master (
    output transfer_cmd_valid, transfer_cmd_data, transfer_eve_ready,
    output cmd_ready, eve_valid, eve_data, eve_chid,
    input  transfer_cmd_ready, transfer_eve_valid, transfer_eve_data,
    input  cmd_valid, cmd_data, cmd_chid, eve_ready, eve_drop_cnt
  );
endinterface

// File: rtl/cif_mchbuf.sv
// rtl/cif_mchbuf.sv - per-channel command FIFOs with round-robin arbiter and event demux FIFOs
module cif_mchbuf #(
  parameter int CH_NUM    = 4,
  parameter int CMD_W     = 64,
  parameter int EVE_W     = 128,
  parameter int CMD_DEPTH = 8,
  parameter int EVE_DEPTH = 8,
  parameter int CHID_W    = 4
) (
  input logic         user_clk,
  input logic         reset_n,
  cif_mchbuf_if.slave bus
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int EAW = $clog2(EVE_DEPTH);
  localparam int SW  = $clog2(CH_NUM);

  if ((2 ** CHID_W) < CH_NUM) begin : g_bad_chid
    $error("cif_mchbuf: CHID_W cannot address CH_NUM channels");
  end
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
    $error("cif_mchbuf: CMD_DEPTH must be a power of 2 and at least 2");
  end
  if (EVE_DEPTH < 2 || (EVE_DEPTH & (EVE_DEPTH - 1)) != 0) begin : g_bad_eve_depth
    $error("cif_mchbuf: EVE_DEPTH must be a power of 2 and at least 2");
  end

  function automatic logic [SW-1:0] ch_wrap(input int v);
    return SW'((v >= CH_NUM) ? v - CH_NUM : v);
  endfunction

  // command side
  logic [CMD_W-1:0]  cmem [CH_NUM][CMD_DEPTH];
  logic [CAW-1:0]    cwp  [CH_NUM];
  logic [CAW-1:0]    crp  [CH_NUM];
  logic [CAW:0]      ccnt [CH_NUM];
  logic              rdy_en;
  logic [CH_NUM-1:0] cmd_rdy, cpush, cpop;
  logic [SW-1:0]     rr_ptr, sel;
  logic              found, load;

  // event side
  logic [EVE_W-1:0]        emem [CH_NUM][EVE_DEPTH];
  logic [EAW-1:0]          ewp  [CH_NUM];
  logic [EAW-1:0]          erp  [CH_NUM];
  logic [EAW:0]            ecnt [CH_NUM];
  logic [CH_NUM-1:0]       epush, epop, evld;
  logic                    eve_rdy, eve_legal;
  logic [CH_NUM*EVE_W-1:0] eve_out;
  logic [15:0]             drop_cnt;

  // Upstream ready comes from registered counts only, held low until the first edge out of reset
  always_comb begin
    cmd_rdy = '0;
    cpush   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cmd_rdy[i] = rdy_en && (ccnt[i] < (CAW + 1)'(CMD_DEPTH));
      cpush[i]   = bus.transfer_cmd_valid[i] && cmd_rdy[i];
    end
  end

  // First non-empty channel at or after rr_ptr wins when the output register can take a word
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cpop  = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (!found && ccnt[ch_wrap(int'(rr_ptr) + k)] != '0) begin
        found = 1'b1;
        sel   = ch_wrap(int'(rr_ptr) + k);
      end
    end
    load = found && (!bus.cmd_valid || bus.cmd_ready);
    for (int i = 0; i < CH_NUM; i++) begin
      cpop[i] = load && (sel == SW'(i));
    end
  end

  // Command storage is unreset; occupancy counts gate every read
  always_ff @(posedge user_clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (cpush[i]) cmem[i][cwp[i]] <= bus.transfer_cmd_data[i*CMD_W +: CMD_W];
    end
  end

  // Command FIFO pointers and occupancy; push and pop together leave the count alone
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        cwp[i]  <= '0;
        crp[i]  <= '0;
        ccnt[i] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      for (int i = 0; i < CH_NUM; i++) begin
        if (cpush[i]) cwp[i] <= cwp[i] + 1'b1;
        if (cpop[i])  crp[i] <= crp[i] + 1'b1;
        case ({cpush[i], cpop[i]})
          2'b10:   ccnt[i] <= ccnt[i] + 1'b1;
          2'b01:   ccnt[i] <= ccnt[i] - 1'b1;
          default: ccnt[i] <= ccnt[i];
        endcase
      end
    end
  end

  // Output register: loads the winner and advances the rotation, holds while stalled
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cmd_valid <= 1'b0;
      bus.cmd_data  <= '0;
      bus.cmd_chid  <= '0;
      rr_ptr        <= '0;
    end else if (load) begin
      bus.cmd_valid <= 1'b1;
      bus.cmd_data  <= cmem[sel][crp[sel]];
      bus.cmd_chid  <= CHID_W'(sel);
      rr_ptr        <= ch_wrap(int'(sel) + 1);
    end else if (bus.cmd_ready) begin
      bus.cmd_valid <= 1'b0;
    end
  end

  // Event demux: illegal IDs are always accepted so they can be discarded
  always_comb begin
    eve_legal = (int'(bus.eve_chid) < CH_NUM);
    eve_rdy   = 1'b1;
    epush     = '0;
    epop      = '0;
    evld      = '0;
    eve_out   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      evld[i] = (ecnt[i] != '0);
      if (eve_legal && bus.eve_chid == CHID_W'(i)) eve_rdy = (ecnt[i] < (EAW + 1)'(EVE_DEPTH));
      if (evld[i]) eve_out[i*EVE_W +: EVE_W] = emem[i][erp[i]];
      epop[i] = evld[i] && bus.transfer_eve_ready[i];
    end
    for (int i = 0; i < CH_NUM; i++) begin
      epush[i] = bus.eve_valid && eve_rdy && eve_legal && (bus.eve_chid == CHID_W'(i));
    end
  end

  assign bus.transfer_cmd_ready = cmd_rdy;
  assign bus.eve_ready          = eve_rdy;
  assign bus.transfer_eve_valid = evld;
  assign bus.transfer_eve_data  = eve_out;
  assign bus.eve_drop_cnt       = drop_cnt;

  // Event storage is unreset; the head is only exposed while the count is non-zero
  always_ff @(posedge user_clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (epush[i]) emem[i][ewp[i]] <= bus.eve_data;
    end
  end

  // Event FIFO pointers, occupancy and the saturating drop counter
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        ewp[i]  <= '0;
        erp[i]  <= '0;
        ecnt[i] <= '0;
      end
    end else begin
      if (bus.eve_valid && !eve_legal && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      for (int i = 0; i < CH_NUM; i++) begin
        if (epush[i]) ewp[i] <= ewp[i] + 1'b1;
        if (epop[i])  erp[i] <= erp[i] + 1'b1;
        case ({epush[i], epop[i]})
          2'b10:   ecnt[i] <= ecnt[i] + 1'b1;
          2'b01:   ecnt[i] <= ecnt[i] - 1'b1;
          default: ecnt[i] <= ecnt[i];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cif_mchbuf.sv
// tb/tb_cif_mchbuf.sv - scoreboard bench for cif_mchbuf
module tb_cif_mchbuf;
  localparam int CH = 4, CW = 64, EW = 128, DEPTH = 8;

  logic user_clk = 1'b0;
  logic reset_n;
  int   total = 0, bad = 0, cyc = 0, left, mc, ec;
  bit   chk_en = 1'b0, acc;

  cif_mchbuf_if #(.CH_NUM(CH), .CMD_W(CW), .EVE_W(EW), .CHID_W(4)) bus ();

  cif_mchbuf #(.CH_NUM(CH), .CMD_W(CW), .EVE_W(EW), .CMD_DEPTH(DEPTH),
               .EVE_DEPTH(DEPTH), .CHID_W(4))
    dut (.user_clk(user_clk), .reset_n(reset_n), .bus(bus));

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  logic [CW-1:0] src     [CH][$];
  logic [CW-1:0] exp_cmd [CH][$];
  logic [EW-1:0] exp_eve [CH][$];
  int            drops;
  int            eve_out_n [CH];
  int            obs_chid[$], obs_cyc[$];
  int            first_acc, first_vld;
  bit            prev_hold;
  logic [CW-1:0] prev_data;
  logic [3:0]    prev_chid;
  logic [CH-1:0] eready;

  assign bus.transfer_eve_ready = eready;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int srcs_left();
    int s = 0;
    for (int i = 0; i < CH; i++) s += src[i].size();
    return s;
  endfunction

  function automatic int cmd_pending();
    int s = 0;
    for (int i = 0; i < CH; i++) s += exp_cmd[i].size();
    return s;
  endfunction

  // command scoreboard: push on upstream accept, pop and compare on downstream accept
  always @(negedge user_clk) begin
    if (reset_n && chk_en) begin
      for (int i = 0; i < CH; i++) begin
        if (bus.transfer_cmd_valid[i] && bus.transfer_cmd_ready[i]) begin
          exp_cmd[i].push_back(bus.transfer_cmd_data[i*CW +: CW]);
          if (first_acc < 0) first_acc = cyc;
        end
      end
      if (prev_hold) begin
        chk("cmd_hold_valid", bus.cmd_valid, 1);
        chk("cmd_hold_data", bus.cmd_data, prev_data);
        chk("cmd_hold_chid", bus.cmd_chid, prev_chid);
      end
      if (bus.cmd_valid && first_vld < 0) first_vld = cyc;
      if (bus.cmd_valid && bus.cmd_ready) begin
        mc = int'(bus.cmd_chid);
        if (mc >= CH || exp_cmd[mc].size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_unexpected: got ch%0d data %0h want no output", mc, bus.cmd_data);
        end else begin
          chk("cmd_data", bus.cmd_data, exp_cmd[mc].pop_front());
        end
        obs_chid.push_back(mc);
        obs_cyc.push_back(cyc);
      end
      prev_hold = bus.cmd_valid && !bus.cmd_ready;
      prev_data = bus.cmd_data;
      prev_chid = bus.cmd_chid;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // event scoreboard: per-channel queues stand in for the FIFOs
  always @(negedge user_clk) begin
    if (reset_n && chk_en) begin
      ec = int'(bus.eve_chid);
      chk("eve_ready", bus.eve_ready, (ec >= CH) ? 1'b1 : (exp_eve[ec].size() < DEPTH));
      chk("eve_drop_cnt", bus.eve_drop_cnt, drops);
      for (int i = 0; i < CH; i++) begin
        chk("eve_valid", bus.transfer_eve_valid[i], exp_eve[i].size() != 0);
        if (bus.transfer_eve_valid[i] && eready[i] && exp_eve[i].size() != 0) begin
          chk("eve_data", bus.transfer_eve_data[i*EW +: EW], exp_eve[i].pop_front());
          eve_out_n[i]++;
        end
      end
      if (bus.eve_valid && bus.eve_ready) begin
        if (ec < CH) exp_eve[ec].push_back(bus.eve_data);
        else if (drops < 65535) drops++;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_data", bus.cmd_data, 0);
    chk("rst_cmd_chid", bus.cmd_chid, 0);
    chk("rst_eve_valid", bus.transfer_eve_valid, 0);
    chk("rst_eve_data", bus.transfer_eve_data, 0);
    chk("rst_cmd_ready", bus.transfer_cmd_ready, 0);
    chk("rst_drop_cnt", bus.eve_drop_cnt, 0);
    bus.transfer_cmd_valid = '0;
    bus.eve_valid = 1'b0;
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < CH; i++) begin
      src[i].delete();
      exp_cmd[i].delete();
      exp_eve[i].delete();
      eve_out_n[i] = 0;
    end
    drops = 0;
    prev_hold = 1'b0;
    obs_chid.delete();
    obs_cyc.delete();
    @(posedge user_clk);
    #1;
    reset_n = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    chk("ready_after_reset", bus.transfer_cmd_ready, 4'hF);
    @(posedge user_clk);
    #1;
  endtask

  // rdy_mode: 0 hold cmd_ready low, 1 hold high, 2 random
  task automatic pump(input int rdy_mode, input bit gap, input int budget, output int rem);
    bit hs [CH];
    int n = 0;
    @(posedge user_clk);
    #1;
    while (n < budget && srcs_left() != 0) begin
      for (int c = 0; c < CH; c++) begin
        bus.transfer_cmd_valid[c] = (src[c].size() != 0) && (!gap || $urandom_range(0, 3) != 0);
        bus.transfer_cmd_data[c*CW +: CW] = (src[c].size() != 0) ? src[c][0] : '0;
      end
      bus.cmd_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      @(negedge user_clk);
      for (int c = 0; c < CH; c++) hs[c] = bus.transfer_cmd_valid[c] && bus.transfer_cmd_ready[c];
      @(posedge user_clk);
      #1;
      for (int c = 0; c < CH; c++) if (hs[c]) void'(src[c].pop_front());
      n++;
    end
    bus.transfer_cmd_valid = '0;
    rem = srcs_left();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.cmd_ready = 1'b1;
    while (n < budget && cmd_pending() != 0) begin
      @(negedge user_clk);
      n++;
    end
    chk("drain_done", cmd_pending(), 0);
    repeat (3) @(posedge user_clk);
    #1;
  endtask

  task automatic send_eve(input logic [3:0] id, input logic [EW-1:0] d, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    bus.eve_valid = 1'b1;
    bus.eve_chid  = id;
    bus.eve_data  = d;
    while (!ok && n < budget) begin
      @(negedge user_clk);
      if (bus.eve_ready) ok = 1'b1;
      n++;
      @(posedge user_clk);
      #1;
    end
    bus.eve_valid = 1'b0;
  endtask

  function automatic logic [EW-1:0] rnd_eve();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    bus.transfer_cmd_valid = '0;
    bus.transfer_cmd_data  = '0;
    bus.cmd_ready = 1'b0;
    bus.eve_valid = 1'b0;
    bus.eve_data  = '0;
    bus.eve_chid  = '0;
    eready = '0;
    @(posedge user_clk);
    #1;
    do_reset();
    chk_en = 1'b1;

    // three commands on ch2, latency and back-to-back output
    first_acc = -1;
    first_vld = -1;
    for (int k = 0; k < 3; k++) src[2].push_back(64'hA0 + 64'(k));
    pump(1, 0, 20, left);
    chk("t1_left", left, 0);
    drain(20);
    chk("t1_latency", first_vld - first_acc, 2);
    chk("t1_count", obs_chid.size(), 3);
    for (int k = 0; k < obs_chid.size(); k++) begin
      chk("t1_chid", obs_chid[k], 2);
      if (k > 0) chk("t1_back_to_back", obs_cyc[k] - obs_cyc[k-1], 1);
    end

    // ch0 backpressure: 8 in FIFO plus 1 in the output register
    obs_chid.delete();
    for (int k = 0; k < 10; k++) src[0].push_back(64'h100 + 64'(k));
    pump(0, 0, 14, left);
    chk("t2_accepted", 10 - left, 9);
    @(negedge user_clk);
    chk("t2_ready0_low", bus.transfer_cmd_ready[0], 0);
    @(posedge user_clk);
    #1;
    pump(1, 0, 20, left);
    chk("t2_left", left, 0);
    drain(40);
    chk("t2_out_count", obs_chid.size(), 10);

    // fairness with every channel preloaded
    do_reset();
    for (int c = 0; c < CH; c++) begin
      src[c].push_back({$urandom, $urandom});
      src[c].push_back({$urandom, $urandom});
    end
    pump(0, 0, 10, left);
    chk("t3_left", left, 0);
    obs_chid.delete();
    drain(30);
    chk("t3_count", obs_chid.size(), 8);
    for (int k = 0; k < obs_chid.size(); k++) chk("t3_rotation", obs_chid[k], k % CH);

    // ch1/ch3 streaming under random backpressure and gaps
    obs_chid.delete();
    for (int k = 0; k < 30; k++) begin
      src[1].push_back({$urandom, $urandom});
      src[3].push_back({$urandom, $urandom});
    end
    pump(2, 1, 400, left);
    chk("t4_left", left, 0);
    drain(100);
    chk("t4_out_count", obs_chid.size(), 60);

    // events to ch1 then two illegal IDs
    eready = '1;
    for (int c = 0; c < CH; c++) eve_out_n[c] = 0;
    for (int k = 0; k < 3; k++) begin
      send_eve(4'd1, rnd_eve(), 10, acc);
      chk("t5_ch1_accept", acc, 1);
    end
    for (int k = 0; k < 2; k++) begin
      send_eve(4'd7, rnd_eve(), 10, acc);
      chk("t5_illegal_accept", acc, 1);
    end
    repeat (4) @(posedge user_clk);
    @(negedge user_clk);
    chk("t5_drop", bus.eve_drop_cnt, 2);
    chk("t5_ch1_out", eve_out_n[1], 3);
    chk("t5_other_out", eve_out_n[0] + eve_out_n[2] + eve_out_n[3], 0);
    @(posedge user_clk);
    #1;

    // fill ch0 events, block the ninth, then reset mid-stream with commands queued
    eready = 4'b1110;
    for (int k = 0; k < 3; k++) src[1].push_back({$urandom, $urandom});
    pump(0, 0, 10, left);
    for (int k = 0; k < DEPTH; k++) begin
      send_eve(4'd0, rnd_eve(), 5, acc);
      chk("t6_fill_accept", acc, 1);
    end
    bus.eve_valid = 1'b1;
    bus.eve_chid  = 4'd0;
    bus.eve_data  = rnd_eve();
    @(negedge user_clk);
    chk("t6_eve_ready_full", bus.eve_ready, 0);
    @(posedge user_clk);
    #1;
    do_reset();
    eready = '1;
    bus.cmd_ready = 1'b1;
    repeat (10) @(posedge user_clk);
    #1;
    chk("t6_no_cmd_after_reset", obs_chid.size(), 0);
    chk("t6_no_eve_after_reset", eve_out_n[0] + eve_out_n[1] + eve_out_n[2] + eve_out_n[3], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
